key_matrix_scanner: RTL

- Drives the column strobes of a passive rows×cols key matrix, reads the row lines back, and debounces every key.
- Emits one press or release event per debounced change over a valid/ready handshake.
- Also exposes the debounced state of all keys.
- Sits between the board-level keypad pins and the CPU-side input port logic.

---
 rtl/key_matrix_scanner.sv | 83 ++++++++
 1 files changed

// File: rtl/key_matrix_scanner.sv
// key_matrix_scanner: strobes matrix columns, debounces every key and reports press/release events over valid/ready
module key_matrix_scanner #(
  parameter int cols = 4,
  parameter int rows = 4,
  parameter int settleBits = 2,
  parameter int debounceBits = 2,
  parameter int keyBits = 4
) (
  input  logic                 clk,
  input  logic                 resetN,
  output logic [cols-1:0]      colOut,
  input  logic [rows-1:0]      rowIn,
  output logic [rows*cols-1:0] keysDown,
  output logic                 eventValid,
  input  logic                 eventReady,
  output logic [keyBits-1:0]   eventKey,
  output logic                 eventPressed
);
  localparam int CW = cols > 1 ? $clog2(cols) : 1;
  localparam int RW = rows > 1 ? $clog2(rows) : 1;
  typedef enum logic [1:0] {SETTLE, EVAL, NEXT} state_t;
  state_t state, state_next;
  logic [rows-1:0] row_s1, row_s2, sample;
  logic [settleBits-1:0] settle_cnt;
  logic [CW-1:0] col_idx;
  logic [RW-1:0] row_idx;
  logic [debounceBits-1:0] cnt [rows*cols];
  logic [keyBits-1:0] key;
  logic raw, differ, pending, stall, load;
  assign colOut = ~(cols'(1) << col_idx);
  assign key = keyBits'(col_idx * rows + row_idx);
  always_ff @(posedge clk) {row_s2, row_s1} <= {row_s1, rowIn};
  always_comb begin
    raw = sample[row_idx];
    differ = raw != keysDown[key];
    pending = state == EVAL && differ && &cnt[key];
    stall = pending && eventValid && !eventReady;
    load = pending && !stall;
    state_next = (state == SETTLE && &settle_cnt) ? EVAL :
                 (state == EVAL && !stall && row_idx == RW'(rows - 1)) ? NEXT :
                 (state == NEXT) ? SETTLE : state;
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) state <= SETTLE;
    else state <= state_next;
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      settle_cnt <= '0;
      col_idx <= '0;
      row_idx <= '0;
      sample <= '0;
      keysDown <= '0;
      eventValid <= 1'b0;
      eventKey <= '0;
      eventPressed <= 1'b0;
      for (int i = 0; i < rows * cols; i++) cnt[i] <= '0;
    end else begin
      if (eventValid && eventReady) eventValid <= 1'b0;
      case (state)
        SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (&settle_cnt) begin
            sample <= ~row_s2;
            row_idx <= '0;
          end
        end
        EVAL: if (!stall) begin
          // a load in the same cycle as an accept overrides the clear above
          cnt[key] <= (differ && !pending) ? cnt[key] + 1'b1 : '0;
          row_idx <= row_idx + 1'b1;
          if (load) begin
            keysDown[key] <= raw;
            eventKey <= key;
            eventPressed <= raw;
            eventValid <= 1'b1;
          end
        end
        NEXT: col_idx <= (col_idx == CW'(cols - 1)) ? '0 : col_idx + 1'b1;
        default: ;
      endcase
    end
  end
endmodule
